// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the 4-digit scan controller.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  // Segment order {g,f,e,d,c,b,a}; 0 lights a segment.
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // A digit is a leading zero when it and every more significant nibble are zero.
  function automatic logic lz_dark(logic [15:0] v, digit_idx_t k);
    logic dark;
    case (k)
      2'd3:    dark = (v[15:12] == 4'h0);
      2'd2:    dark = (v[15:8] == 8'h00);
      2'd1:    dark = (v[15:4] == 12'h000);
      default: dark = 1'b0;
    endcase
    return dark;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Value-producer and display-pin signals of the scan controller.
interface seg7_scan_ctrl_if;

  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic        load_ack;
  logic        frame_tk;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (
    output load, value, dp_in, blank_lz, blink_en,
    input  load_ack, frame_tk, seg, dp, an
  );

  modport slave (
    input  load, value, dp_in, blank_lz, blink_en,
    output load_ack, frame_tk, seg, dp, an
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller with frame-aligned value commit, blink and
// leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYC    = 2000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
  localparam logic [FrmW-1:0] FrmLast  = FrmW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            phase_q, phase_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [15:0]     stage_q, stage_d;
  logic [3:0]      stage_dp_q, stage_dp_d;
  logic            pending_q, pending_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       slot_end;
  logic       boundary;
  logic       commit;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic       dark;

  assign slot_end = (cnt_q == CntLast);
  assign boundary = slot_end && (idx_q == 2'd3);
  assign commit   = boundary && (pending_q || bus.load);
  assign cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Scan timing, staging and commit.
  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
    frm_d       = frm_q;
    phase_d     = phase_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    stage_d     = stage_q;
    stage_dp_d  = stage_dp_q;
    pending_d   = pending_q;

    if (bus.load) begin
      stage_d    = bus.value;
      stage_dp_d = bus.dp_in;
      pending_d  = 1'b1;
    end

    if (boundary) begin
      pending_d = 1'b0;
      if (bus.load) begin
        shadow_d    = bus.value;
        shadow_dp_d = bus.dp_in;
      end else if (pending_q) begin
        shadow_d    = stage_q;
        shadow_dp_d = stage_dp_q;
      end
      if (frm_q == FrmLast) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FrmW'(1);
      end
    end
  end

  // Slot output, registered one cycle behind the counter and index.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    dark  = (phase_q && bus.blink_en[idx_q]) || (bus.blank_lz && lz_dark(shadow_q, idx_q));
    if (cnt_q >= BlankEnd) begin
      an_d = ~(4'b0001 << idx_q);
      if (!dark) begin
        seg_d = dec_seg;
        dp_d  = ~shadow_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      phase_q     <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      stage_q     <= '0;
      stage_dp_q  <= '0;
      pending_q   <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      stage_q     <= stage_d;
      stage_dp_q  <= stage_dp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.frame_tk = boundary & ~reset;
  assign bus.load_ack = commit & ~reset;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic reset;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .REFRESH_DIV  (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen = 0;

  // Bench model: cycles since reset release plus the load/commit bookkeeping.
  int          m_t = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_sdp = '0;
  logic [15:0] m_stage = '0;
  logic [3:0]  m_stage_dp = '0;
  logic        m_pend = 1'b0;
  logic [11:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // Expected {an, seg, dp} one cycle after scan position t.
  function automatic logic [11:0] exp_scan(input int t, input logic [15:0] v,
                                           input logic [3:0] dpv, input logic lz,
                                           input logic [3:0] ben);
    int         d;
    logic [3:0] an;
    logic       dark;
    d = (t / 4) % 4;
    if ((t % 4) < 1) return 12'hFFF;
    an    = 4'hF;
    an[d] = 1'b0;
    dark  = (((t / 32) % 2) == 1 && ben[d]) || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
    if (dark) return {an, 7'h7F, 1'b1};
    return {an, hex7(v[4*d +: 4]), ~dpv[d]};
  endfunction

  task automatic tick();
    logic [11:0] exp_o;
    logic        bnd;
    logic        ack_e;
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      check_eq("scan", {20'h0, bus.an, bus.seg, bus.dp}, {20'h0, exp_o});
    end
    bnd   = !reset && ((m_t % 16) == 15);
    ack_e = bnd && (m_pend || bus.load);
    check_eq("frame_tk", {31'h0, bus.frame_tk}, {31'h0, bnd});
    check_eq("load_ack", {31'h0, bus.load_ack}, {31'h0, ack_e});
    if (bus.load_ack) ack_seen++;
    if (reset) begin
      sb.push_back(12'hFFF);
      m_t = 0; m_shadow = '0; m_sdp = '0; m_stage = '0; m_stage_dp = '0; m_pend = 1'b0;
    end else begin
      sb.push_back(exp_scan(m_t, m_shadow, m_sdp, bus.blank_lz, bus.blink_en));
      if (bnd) begin
        if (bus.load) begin
          m_shadow = bus.value; m_sdp = bus.dp_in;
        end else if (m_pend) begin
          m_shadow = m_stage; m_sdp = m_stage_dp;
        end
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_stage = bus.value; m_stage_dp = bus.dp_in; m_pend = 1'b1;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench one cycle before a frame boundary.
  task automatic run_to_boundary();
    for (int i = 0; i < 16 && (m_t % 16) != 15; i++) tick();
  endtask

  task automatic load_pulse(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 4'h0;

    // Reset, then a full scan of value 0.
    run(3);
    reset = 1'b0;
    run(20);

    // Mid-frame load commits at the next boundary.
    run(5);
    load_pulse(16'h12AF);
    run(40);

    // Two loads in one frame: last wins, single ack.
    run_to_boundary();
    tick();
    run(3);
    ack_seen = 0;
    load_pulse(16'h1111);
    run(2);
    load_pulse(16'h2222);
    run_to_boundary();
    tick();
    check_eq("single_ack", ack_seen, 1);
    run(16);

    // Load coinciding with the boundary, leading-zero blanking.
    run_to_boundary();
    bus.blank_lz = 1'b1;
    load_pulse(16'h0042);
    run(16);
    run_to_boundary();
    load_pulse(16'h0000);
    run(16);

    // Blink on digit 0 with a decimal point on digit 1.
    bus.blank_lz = 1'b0;
    bus.blink_en = 4'b0001;
    bus.dp_in    = 4'b0010;
    load_pulse(16'h1234);
    run(130);

    // Reset while a load is pending mid-slot.
    bus.blink_en = 4'h0;
    bus.dp_in    = 4'h0;
    run_to_boundary();
    tick();
    run(6);
    load_pulse(16'hABCD);
    ack_seen = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(40);
    check_eq("no_ack_after_reset", ack_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
